// File: rtl/message_stream_buffer_pkg.sv
// Shared FSM encoding and default widths for the message stream buffer.
package message_stream_buffer_pkg;
  localparam int MSG_W_DEF = 64;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    STREAM = ST_STREAM,
    DRAIN  = ST_DRAIN,
    DONE   = ST_DONE
  } state_t;
endpackage

// File: rtl/message_stream_buffer_fifo.sv
// Show-ahead FIFO core: storage, wrapping pointers and a separate 0..DEPTH level.
module msg_fifo_core #(
  parameter int DEPTH_LOG2 = 4,
  parameter int MSG_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [MSG_W-1:0]      wdata,
  output logic [MSG_W-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

  logic [MSG_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  clr, push_q, pop_q;

  assign clr    = rst | flush;
  assign push_q = push & ~clr;
  assign pop_q  = pop & ~clr;

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_q) wr_ptr <= wr_ptr + 1'b1;
      if (pop_q)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_q, pop_q})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by level alone.
  always_ff @(posedge clk) begin
    if (push_q) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
endmodule

// File: rtl/message_stream_buffer.sv
// Buffers counter words for the DES core, throttles the counter and flags region end.
// Optional stats counters enabled by MESSAGE_STREAM_BUFFER_STATS_EN.
module message_stream_buffer
  import message_stream_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2   = 4,
  parameter int PAUSE_MARGIN = 4,
  parameter int MSG_W        = MSG_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [MSG_W-1:0]    in_data,
  input  logic                in_done,
  output logic                pause,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MSG_W-1:0]    out_data,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  output logic                drained
`ifdef MESSAGE_STREAM_BUFFER_STATS_EN
  ,
  output logic [31:0]         accepted_cnt,
  output logic [31:0]         dropped_cnt
`endif
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PAUSE_LVL = (DEPTH_LOG2+1)'(DEPTH - PAUSE_MARGIN);

  logic clr, full, empty, push, pop, drop;
  logic [DEPTH_LOG2:0] lvl_nxt;
  state_t state, st_nxt;

  assign clr  = rst | flush;
  assign pop  = out_valid & out_ready & ~clr;
  assign push = in_valid & (~full | pop) & ~clr;
  assign drop = in_valid & full & ~pop & ~clr;
  assign out_valid = ~empty;

  msg_fifo_core #(.DEPTH_LOG2(DEPTH_LOG2), .MSG_W(MSG_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    lvl_nxt = level;
    case ({push, pop})
      2'b10:   lvl_nxt = level + 1'b1;
      2'b01:   lvl_nxt = level - 1'b1;
      default: lvl_nxt = level;
    endcase
  end

  // in_done is held by the counter; only IDLE/STREAM react to it.
  always_comb begin
    st_nxt = state;
    case (state)
      IDLE:    if (in_done) st_nxt = DRAIN; else if (push) st_nxt = STREAM;
      STREAM:  if (in_done) st_nxt = DRAIN;
      DRAIN:   if (level == '0 && !push) st_nxt = DONE;
      default: st_nxt = state;
    endcase
  end

  // Outputs registered against the state being entered, so pause stays low in IDLE/DONE.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      pause    <= 1'b0;
      overflow <= 1'b0;
      drained  <= 1'b0;
    end else begin
      state    <= st_nxt;
      pause    <= (st_nxt == STREAM || st_nxt == DRAIN) && (lvl_nxt >= PAUSE_LVL);
      drained  <= (st_nxt == DONE);
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef MESSAGE_STREAM_BUFFER_STATS_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      accepted_cnt <= '0;
      dropped_cnt  <= '0;
    end else begin
      if (push && accepted_cnt != '1) accepted_cnt <= accepted_cnt + 1'b1;
      if (drop && dropped_cnt != '1)  dropped_cnt  <= dropped_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_message_stream_buffer.sv
// Scoreboard bench for message_stream_buffer: queue model of accepted words plus level/overflow model.
module tb_message_stream_buffer;
  import message_stream_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_done, out_ready;
  logic [63:0] in_data;
  logic        pause, out_valid, overflow, drained;
  logic [63:0] out_data;
  logic [4:0]  level;
`ifdef MESSAGE_STREAM_BUFFER_STATS_EN
  logic [31:0] accepted_cnt, dropped_cnt;
`endif

  message_stream_buffer #(.DEPTH_LOG2(4), .PAUSE_MARGIN(4), .MSG_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_done   (in_done),
    .pause     (pause),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow),
    .drained   (drained)
`ifdef MESSAGE_STREAM_BUFFER_STATS_EN
    ,
    .accepted_cnt (accepted_cnt),
    .dropped_cnt  (dropped_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  int          mlevel = 0;
  logic        movf = 1'b0;
  int          macc = 0;
  int          mdrop = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock: drive, check head before the edge, update model at the edge, check state after it.
  task automatic cyc(input logic iv, input logic [63:0] d, input logic ir,
                     input logic dn, input logic fl);
    logic mpop, mpush;
    in_valid = iv; in_data = d; out_ready = ir; in_done = dn; flush = fl;
    @(negedge clk);
    mpop = (mlevel != 0) && ir && !fl;
    chk("out_valid", out_valid, mlevel != 0);
    if (mpop) chk("out_data", out_data, exp_q[0]);
    @(posedge clk);
    if (fl) begin
      exp_q.delete(); mlevel = 0; movf = 1'b0; macc = 0; mdrop = 0;
    end else begin
      mpush = iv && (mlevel < 16 || mpop);
      if (mpop) begin void'(exp_q.pop_front()); mlevel--; end
      if (mpush) begin exp_q.push_back(d); mlevel++; macc++; end
      else if (iv) begin movf = 1'b1; mdrop++; end
    end
    #1;
    chk("level", level, mlevel);
    chk("overflow", overflow, movf);
`ifdef MESSAGE_STREAM_BUFFER_STATS_EN
    chk("accepted_cnt", accepted_cnt, macc);
    chk("dropped_cnt", dropped_cnt, mdrop);
`endif
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_done = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pause", pause, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drained", drained, 0);
    chk("rst_state", 64'(dut.state), 64'(ST_IDLE));
    rst = 1'b0;

    // Steady flow: each word leaves one cycle after entering.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 64'(i), 1'b1, 1'b0, 1'b0);
      chk("flow_pause", pause, 0);
      chk("flow_level_le1", level <= 5'd1, 1);
    end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Backpressure: pause tracks level >= 12, including the 2 skid words.
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 64'(32 + i), 1'b0, 1'b0, 1'b0);
      chk("bp_pause_fill", pause, mlevel >= 12);
    end
    for (int i = 0; i < 2; i++) cyc(1'b1, 64'(60 + i), 1'b0, 1'b0, 1'b0);
    chk("bp_skid_level", level, 14);
    chk("bp_skid_pause", pause, 1);
    chk("bp_skid_ovf", overflow, 0);
    while (mlevel > 0) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("bp_pause_drain", pause, mlevel >= 12);
    end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Overflow: 17th word is lost.
    for (int i = 0; i < 17; i++) cyc(1'b1, 64'(100 + i), 1'b0, 1'b0, 1'b0);
    chk("ovf_level", level, 16);
    chk("ovf_flag", overflow, 1);
`ifdef MESSAGE_STREAM_BUFFER_STATS_EN
    chk("ovf_dropped", dropped_cnt, 1);
    chk("ovf_accepted", accepted_cnt, 16);
`endif
    while (mlevel > 0) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("ovf_sticky", overflow, 1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 16; i++) cyc(1'b1, 64'(200 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h300, 1'b1, 1'b0, 1'b0);
    chk("fullpp_level", level, 16);
    chk("fullpp_ovf", overflow, 0);
    while (mlevel > 0) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Region end: DRAIN then DONE one cycle after level reaches 0.
    for (int i = 0; i < 5; i++) cyc(1'b1, 64'(400 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("reg_state_drain", 64'(dut.state), 64'(ST_DRAIN));
    chk("reg_drained0", drained, 0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("reg_drained_lvl0", drained, 0);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("reg_drained1", drained, 1);
    chk("reg_done_pause", pause, 0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("reg_flush_drained", drained, 0);

    // Flush mid-stream with a pop presented in the flush cycle.
    for (int i = 0; i < 7; i++) cyc(1'b1, 64'(500 + i), 1'b0, 1'b0, 1'b0);
    chk("fl_pre_level", level, 7);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_state", 64'(dut.state), 64'(ST_IDLE));
    cyc(1'b1, 64'hA5, 1'b0, 1'b0, 1'b0);
    chk("fl_new_valid", out_valid, 1);
    chk("fl_new_data", out_data, 64'hA5);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/message_stream_buffer.md
Name: message_stream_buffer

Overview:
- Sits directly downstream of the partial message counter and upstream of the DES core.
- Captures every counter word presented with valid high and buffers it in a show-ahead FIFO.
- Hands words to the DES core over a valid/ready handshake.
- Drives the counter's pause input so the counter never overruns the buffer, and reports when a region has been fully consumed.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16).
- PAUSE_MARGIN, 4, free-slot threshold at which pause is raised; must be >= 2 and < DEPTH.
- MSG_W, 64, message width.

Ports:
- clk  in  1  single clock, all logic posedge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous flush, driven alongside the counter's reset_counter.
- in_valid  in  1  counter valid.
- in_data  in  MSG_W  counter word.
- in_done  in  1  counter done (region exhausted).
- pause  out  1  registered pause to counter.
- out_valid  out  1  head word available.
- out_ready  in  1  DES core accepts head word.
- out_data  out  MSG_W  head word.
- level  out  DEPTH_LOG2+1  current occupancy.
- overflow  out  1  sticky: a word was dropped.
- drained  out  1  region complete and buffer empty.

Behaviour:
- Reset (rst=1) values: FIFO empty, level=0, pause=0, out_valid=0, overflow=0, drained=0, state=IDLE. flush=1 gives the same result; rst takes priority.
- Push: occurs when in_valid=1 and the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - in_valid=1 with full and no pop: word dropped, overflow set (sticky until rst/flush).
- Pop: occurs when out_valid=1 and out_ready=1.
  - Simultaneous push and pop leaves level unchanged.
- Show-ahead head:
  - out_valid = (level != 0).
  - out_data = entry at the read pointer; it is valid in the same cycle out_valid rises.
  - Latency from push to out_valid: 1 cycle.
- Pointers: DEPTH_LOG2 bits, wrap modulo DEPTH. level is maintained separately and covers 0..DEPTH.
- Pause:
  - Registered: pause <= (next_level >= DEPTH - PAUSE_MARGIN).
  - The counter emits at most 2 further words after the cycle where the threshold is crossed, so PAUSE_MARGIN >= 2 guarantees no overflow with a compliant counter.
  - pause is forced to 0 in IDLE and DONE.
- FSM states:
  - IDLE: wait. The first accepted in_valid moves to STREAM.
  - STREAM: buffer normally. A cycle with in_done=1 moves to DRAIN.
    - If in_done=1 arrives in IDLE, go directly to DRAIN.
  - DRAIN: no further pushes expected; in_valid is still honoured. Move to DONE when level==0 with no push that cycle.
  - DONE: drained=1. Stay until flush/rst, which return to IDLE.
- Flush mid-operation:
  - Discards all buffered words immediately; out_valid falls the next cycle.
  - A pop presented in the flush cycle is ignored.
- in_done is level-sensitive (the counter holds done); only its first observation matters.

Optional Feature:
- Macro: MESSAGE_STREAM_BUFFER_STATS_EN.
- With the macro: adds outputs accepted_cnt[31:0] and dropped_cnt[31:0].
  - accepted_cnt increments on every push; dropped_cnt increments on every drop.
  - Both saturate at 2^32-1 and clear on rst/flush.
- Without the macro: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package: FSM state encoding (IDLE/STREAM/DRAIN/DONE as 2-bit localparams) and the default MSG_W.
- One natural sub-module, msg_fifo_core: storage array, pointers and level, with push/pop/flush inputs and full/empty/level outputs.
- The top level holds the FSM, pause, overflow and stats.

Test Plan:
- Steady flow: in_valid=1 for 20 cycles with words 0..19, out_ready=1 -> out_data sequence 0..19 in order, each 1 cycle after push, level never exceeds 1, pause stays 0.
- Backpressure: out_ready=0, in_valid=1 -> pause=1 the cycle after level reaches 12. Feed 2 skid words -> level=14, overflow=0. Release out_ready -> pause falls once level <= 11.
- Overflow: out_ready=0, ignore pause and push 17 words -> level=16, overflow=1, word 16 lost. With stats enabled, dropped_cnt=1 and accepted_cnt=16.
- Full with simultaneous push/pop: level=16, in_valid=1, out_ready=1 -> push accepted, level stays 16, overflow stays 0.
- Region end: push 5 words, then in_done=1 while out_ready=0 -> state DRAIN, drained=0. Pop all 5 -> drained=1 the cycle after level hits 0.
- Flush mid-stream: level=7, flush=1 -> next cycle level=0, out_valid=0, overflow=0, state IDLE. A new word 0xA5 is accepted normally afterwards.
